// File: rtl/rtd_pkg.sv
// Shared types and constants for the reaction-timer display sequencer.
package rtd_pkg;

  localparam int RT_TIME_W = 13;

  typedef enum logic [2:0] {
    IDLE,
    RWAIT,
    REACT,
    SHOW,
    EARLY,
    SLOW
  } rt_state_t;

  typedef enum logic [1:0] {
    DISP_BLANK,
    DISP_TIME,
    DISP_EARLY,
    DISP_SLOW
  } disp_sel_t;

endpackage

// File: rtl/reaction_timer_ctrl_ms_timebase.sv
// Millisecond timebase: free prescaler producing one ms step, plus a saturating ms counter.
module ms_timebase #(
  parameter int TIME_W     = 13,
  parameter int MS_TICKS   = 100000,
  parameter int TIMEOUT_MS = 5000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  output logic [TIME_W-1:0] ms_cnt
);

  localparam int PRE_W = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(MS_TICKS - 1);
  localparam logic [TIME_W-1:0] MS_SAT   = TIME_W'(TIMEOUT_MS);

  logic [PRE_W-1:0] presc;
  logic             ms_tick;

  assign ms_tick = enable && (presc == PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if (enable) begin
      presc <= ms_tick ? '0 : presc + PRE_W'(1);
      // Hold at the timeout value so the FSM compare can never be skipped by a wrap.
      if (ms_tick && (ms_cnt != MS_SAT)) begin
        ms_cnt <= ms_cnt + TIME_W'(1);
      end
    end
  end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer sequencer: random wait, stimulus LED, ms measurement and display select.
// Optional best-time tracking is enabled with the RT_BEST_TIME_EN macro.
//
//  state | meaning
//  IDLE  | after reset, waiting for start
//  RWAIT | random wait running in the Counter (start_rwait high)
//  REACT | LED lit, measuring ms until stop or timeout
//  SHOW  | valid reaction time displayed
//  EARLY | stop pressed before the LED lit
//  SLOW  | no stop within TIMEOUT_MS
module reaction_timer_ctrl
  import rtd_pkg::*;
#(
  parameter int TIME_W     = RT_TIME_W,
  parameter int MS_TICKS   = 100000,
  parameter int TIMEOUT_MS = 5000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              rwait_done,
  output logic              start_rwait,
  output logic              led,
  output logic [TIME_W-1:0] rt_ms,
  output logic              rt_valid,
  output logic [1:0]        disp_sel
`ifdef RT_BEST_TIME_EN
  ,
  output logic [TIME_W-1:0] best_ms
`endif
);

  if (TIMEOUT_MS >= (2 ** TIME_W)) begin : g_timeout_range
    $error("TIMEOUT_MS does not fit in TIME_W bits");
  end

  rt_state_t         state;
  rt_state_t         state_nxt;
  disp_sel_t         disp_code;
  logic [TIME_W-1:0] ms_cnt;
  logic              timeout;
  logic              react_entry;
  logic              show_entry;
  logic              restart;

  assign timeout     = (ms_cnt == TIME_W'(TIMEOUT_MS));
  assign react_entry = (state == RWAIT) && !stop && rwait_done;
  assign show_entry  = (state == REACT) && stop;
  assign restart     = ((state == SHOW) || (state == EARLY) || (state == SLOW)) && start;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = RWAIT;
      RWAIT: begin
        if (stop)            state_nxt = EARLY;
        else if (rwait_done) state_nxt = REACT;
      end
      REACT: begin
        if (stop)         state_nxt = SHOW;
        else if (timeout) state_nxt = SLOW;
      end
      SHOW, EARLY, SLOW: if (start) state_nxt = RWAIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  ms_timebase #(
    .TIME_W    (TIME_W),
    .MS_TICKS  (MS_TICKS),
    .TIMEOUT_MS(TIMEOUT_MS)
  ) u_timebase (
    .clk   (clk),
    .reset (reset),
    .clear (react_entry),
    .enable(state == REACT),
    .ms_cnt(ms_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rt_ms    <= '0;
      rt_valid <= 1'b0;
    end else if (show_entry) begin
      rt_ms    <= ms_cnt;
      rt_valid <= 1'b1;
    end else if (restart) begin
      rt_valid <= 1'b0;
    end
  end

`ifdef RT_BEST_TIME_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      best_ms <= '1;
    end else if (show_entry && (ms_cnt < best_ms)) begin
      best_ms <= ms_cnt;
    end
  end
`endif

  always_comb begin
    disp_code = DISP_BLANK;
    case (state)
      SHOW:    disp_code = DISP_TIME;
      EARLY:   disp_code = DISP_EARLY;
      SLOW:    disp_code = DISP_SLOW;
      default: disp_code = DISP_BLANK;
    endcase
  end

  assign disp_sel    = disp_code;
  assign start_rwait = (state == RWAIT);
  assign led         = (state == REACT);

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl with a result scoreboard (MS_TICKS=4, TIMEOUT_MS=20).
module tb_reaction_timer_ctrl;
  import rtd_pkg::*;

  localparam int TW  = 13;
  localparam int MST = 4;
  localparam int TMO = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          rwait_done = 1'b0;
  logic          start_rwait;
  logic          led;
  logic [TW-1:0] rt_ms;
  logic          rt_valid;
  logic [1:0]    disp_sel;
`ifdef RT_BEST_TIME_EN
  logic [TW-1:0] best_ms;
`endif

  always #5 clk = ~clk;

  reaction_timer_ctrl #(
    .TIME_W    (TW),
    .MS_TICKS  (MST),
    .TIMEOUT_MS(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .rwait_done (rwait_done),
    .start_rwait(start_rwait),
    .led        (led),
    .rt_ms      (rt_ms),
    .rt_valid   (rt_valid),
    .disp_sel   (disp_sel)
`ifdef RT_BEST_TIME_EN
    ,
    .best_ms    (best_ms)
`endif
  );

  typedef struct {
    int disp;
    int valid;
    int rt;
    int best;
  } exp_t;

  exp_t exp_q[$];
  exp_t got_e;
  int   checks = 0;
  int   errors = 0;
  int   prev_disp = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int d, input int v, input int r, input int b);
    exp_t e;
    e.disp = d; e.valid = v; e.rt = r; e.best = b;
    exp_q.push_back(e);
  endtask

  // Monitor: a result is presented whenever disp_sel leaves BLANK.
  always @(negedge clk) begin
    if (reset) begin
      prev_disp = 0;
    end else begin
      if (disp_sel != 2'd0 && prev_disp == 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got disp_sel %0d, required no result", disp_sel);
        end else begin
          got_e = exp_q.pop_front();
          chk("res_disp_sel", int'(disp_sel), got_e.disp);
          chk("res_rt_valid", int'(rt_valid), got_e.valid);
          chk("res_rt_ms", int'(rt_ms), got_e.rt);
`ifdef RT_BEST_TIME_EN
          chk("res_best_ms", int'(best_ms), got_e.best);
`endif
        end
      end
      prev_disp = int'(disp_sel);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_trial();
    @(negedge clk);
    chk("start_rwait_gap", int'(start_rwait), 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // n cycles in RWAIT; rwait_done/stop applied on the last one.
  task automatic rwait_phase(input int n, input bit done, input bit stp);
    int hi = 0;
    int lit = 0;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) begin
        rwait_done = done;
        stop = stp;
      end
      @(negedge clk);
      if (start_rwait) hi++;
      if (led) lit++;
      cyc();
    end
    rwait_done = 1'b0;
    stop = 1'b0;
    chk("start_rwait_cycles", hi, n);
    chk("led_in_rwait", lit, 0);
  endtask

  // k cycles with the LED lit; stop optionally sampled on the k-th edge after entry.
  task automatic react_phase(input int k, input bit stp);
    int lit = 0;
    for (int i = 0; i < k; i++) begin
      if (i == k - 1) stop = stp;
      @(negedge clk);
      if (led) lit++;
      cyc();
    end
    stop = 1'b0;
    chk("led_cycles", lit, k);
    @(negedge clk);
    chk("led_after_react", int'(led), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_start_rwait"}, int'(start_rwait), 0);
    chk({tag, "_led"}, int'(led), 0);
    chk({tag, "_rt_ms"}, int'(rt_ms), 0);
    chk({tag, "_rt_valid"}, int'(rt_valid), 0);
    chk({tag, "_disp_sel"}, int'(disp_sel), 0);
`ifdef RT_BEST_TIME_EN
    chk({tag, "_best_ms"}, int'(best_ms), 8191);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    cyc();

    // Normal: stop 29 cycles after LED -> 7 ms
    push_exp(1, 1, 7, 7);
    begin_trial();
    rwait_phase(10, 1'b1, 1'b0);
    react_phase(29, 1'b1);
    repeat (3) cyc();

    // Early stop during RWAIT
    push_exp(2, 0, 7, 7);
    begin_trial();
    rwait_phase(5, 1'b0, 1'b1);
    repeat (3) cyc();
    chk("early_led", int'(led), 0);

    // stop and rwait_done together -> EARLY
    push_exp(2, 0, 7, 7);
    begin_trial();
    rwait_phase(3, 1'b1, 1'b1);
    repeat (3) cyc();
    chk("coincide_led", int'(led), 0);

    // Timeout -> SLOW, counter holds at 20
    push_exp(3, 0, 7, 7);
    begin_trial();
    rwait_phase(4, 1'b1, 1'b0);
    react_phase(81, 1'b0);
    repeat (5) cyc();
    chk("slow_ms_cnt_sat", int'(dut.u_timebase.ms_cnt), 20);
    chk("slow_disp_hold", int'(disp_sel), 3);

    // stop on the timeout edge -> SHOW with 20
    push_exp(1, 1, 20, 7);
    begin_trial();
    rwait_phase(2, 1'b1, 1'b0);
    react_phase(81, 1'b1);
    repeat (2) cyc();

    // Mid-trial reset with start held high
    begin_trial();
    rwait_phase(2, 1'b1, 1'b0);
    repeat (10) cyc();
    chk("pre_reset_led", int'(led), 1);
    reset = 1'b1;
    start = 1'b1;
    cyc();
    @(negedge clk);
    check_idle_outputs("midreset");
    cyc();
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");
    cyc();

    // Best-time sequence: 7, EARLY, 3, 9
    push_exp(1, 1, 7, 7);
    begin_trial();
    rwait_phase(6, 1'b1, 1'b0);
    react_phase(29, 1'b1);
    cyc();

    push_exp(2, 0, 7, 7);
    begin_trial();
    rwait_phase(4, 1'b0, 1'b1);
    cyc();

    push_exp(1, 1, 3, 3);
    begin_trial();
    rwait_phase(7, 1'b1, 1'b0);
    react_phase(13, 1'b1);
    cyc();

    push_exp(1, 1, 9, 3);
    begin_trial();
    rwait_phase(3, 1'b1, 1'b0);
    react_phase(37, 1'b1);

    repeat (5) cyc();
    chk("results_outstanding", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
